// File: rtl/rsp_merge_n.sv
// rsp_merge_n: merges CH_NUM response channels through per-channel skid buffers into one FIFO write port.
// Define RSP_MERGE_FIXED_PRIO_EN for lowest-index-first priority; default is round-robin.
module rsp_merge_n #(
  parameter int CH_NUM      = 2,
  parameter int RSP_WIDTH   = 32,
  parameter int BUF_DEPTH   = 4,
  parameter int BLOCK_SLACK = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CH_NUM-1:0]           rsp_write_en_in,
  input  logic [CH_NUM*RSP_WIDTH-1:0] rsp_data_in,
  input  logic                        rsp_fifo_almost_full,
  output logic                        rsp_write_en,
  output logic [RSP_WIDTH-1:0]        rsp_data,
  output logic [CH_NUM-1:0]           src_blocked,
  output logic [CH_NUM-1:0]           overflow_err
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(CH_NUM);
  logic [RSP_WIDTH-1:0] mem_q [CH_NUM][BUF_DEPTH];
  logic [PW-1:0]        rd_q [CH_NUM];
  logic [PW-1:0]        wr_q [CH_NUM];
  logic [CW-1:0]        cnt_q [CH_NUM];
  logic [CH_NUM-1:0]    ne, pop, push, ovf_q;
  logic                 gnt_v, we_q;
  logic [GW-1:0]        gnt_idx;
  logic [RSP_WIDTH-1:0] data_q;
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      ne[i]          = cnt_q[i] != '0;
      pop[i]         = gnt_v && gnt_idx == GW'(i);
      push[i]        = rsp_write_en_in[i] && (cnt_q[i] != CW'(BUF_DEPTH) || pop[i]);
      src_blocked[i] = cnt_q[i] >= CW'(BUF_DEPTH - BLOCK_SLACK);
    end
  end
  assign gnt_v = !rsp_fifo_almost_full && |ne;
`ifdef RSP_MERGE_FIXED_PRIO_EN
  always_comb begin
    gnt_idx = '0;
    for (int k = CH_NUM - 1; k >= 0; k--)
      if (ne[k]) gnt_idx = GW'(k);
  end
`else
  logic [GW-1:0] last_q, cand;
  // scan downward so the last hit is the first candidate after last_grant
  always_comb begin
    gnt_idx = '0;
    cand    = '0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      cand = GW'((int'(last_q) + 1 + k) % CH_NUM);
      if (ne[cand]) gnt_idx = cand;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= GW'(CH_NUM - 1);
    else if (gnt_v) last_q <= gnt_idx;
`endif
  always_ff @(posedge clk)
    for (int i = 0; i < CH_NUM; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= rsp_data_in[i*RSP_WIDTH +: RSP_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      ovf_q  <= '0;
      we_q   <= 1'b0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
        if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
        cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
      ovf_q  <= ovf_q | (rsp_write_en_in & ~push);
      we_q   <= gnt_v;
      data_q <= gnt_v ? mem_q[gnt_idx][rd_q[gnt_idx]] : data_q;
    end
  assign rsp_write_en = we_q;
  assign rsp_data     = data_q;
  assign overflow_err = ovf_q;
endmodule

// File: doc/rsp_merge_n.md
# rsp_merge_n

Parametrised N-channel response merger that collects response writes from several pipeline sources (dispatcher early-fail path, or-tree completion path, future extra trees) and serialises them into a single response FIFO write port. Each channel owns a small skid buffer, so simultaneous responses are never lost. Channels are served by round-robin arbitration, and the merger honours the response FIFO's almost-full back-pressure. It sits between the allocator datapath and the alloc/free response FIFOs, replacing the fixed two-input arbitration in the MMU top level.

## Interface
Parameters:
- CH_NUM, 2, number of source channels (2..8)
- RSP_WIDTH, 32, bits per response word
- BUF_DEPTH, 4, entries per channel buffer; power of two, ≥2
- BLOCK_SLACK, 1, free-entry threshold for asserting src_blocked; must be < BUF_DEPTH

Ports:
- clk  input  1  clock; all logic rising-edge
- rst_n  input  1  reset; one clock, reset asynchronous and active-low
- rsp_write_en_in  input  CH_NUM  per-channel response strobe
- rsp_data_in  input  CH_NUM*RSP_WIDTH  channel i data at [i*RSP_WIDTH +: RSP_WIDTH]
- rsp_fifo_almost_full  input  1  downstream FIFO cannot take further writes
- rsp_write_en  output  1  registered write strobe to response FIFO
- rsp_data  output  RSP_WIDTH  registered response word
- src_blocked  output  CH_NUM  channel i buffer count ≥ BUF_DEPTH−BLOCK_SLACK; upstream must stall
- overflow_err  output  CH_NUM  sticky; a write to channel i was dropped

## Operation
- Per channel: circular buffer with rd/wr pointers of width log2(BUF_DEPTH) that wrap naturally, plus a count of width log2(BUF_DEPTH)+1.
- Push: rsp_write_en_in[i] is accepted if count<BUF_DEPTH, or if count==BUF_DEPTH and channel i is popped in the same cycle. Otherwise the word is dropped and overflow_err[i] is set; the bit stays set until reset.
- Simultaneous push and pop on the same channel leaves count unchanged.
- Arbitration is evaluated every cycle when rsp_fifo_almost_full=0. Candidates are channels with count>0. Grant goes to the first candidate found scanning from (last_grant+1) mod CH_NUM upward.
- last_grant resets to CH_NUM−1, so channel 0 is first after reset. last_grant updates only on an actual grant.
- On a grant, the head word is popped and registered into rsp_data, and rsp_write_en=1 the next cycle. If there is no grant, rsp_write_en=0 and rsp_data holds its last value.
- When rsp_fifo_almost_full=1, no pop occurs, buffers keep filling, and src_blocked throttles the sources.
- src_blocked is decoded from the registered counts with no input lookahead.

## Timing
- Reset values: rsp_write_en=0, rsp_data=0, src_blocked=0, overflow_err=0, all counts and pointers 0.
- Latency: a strobe sampled at edge E0 into an empty buffer of a channel that wins arbitration produces rsp_write_en=1 in the cycle after E1, i.e. 2 cycles.
- Throughput: one output word per cycle while any buffer is non-empty and almost_full=0.
- almost_full sampled high at edge E blocks the pop at E, so at most one write (from the previous grant) follows its assertion.
- Reset asserted mid-operation discards all buffered words asynchronously and clears everything to the reset values.

## Configuration
- RSP_MERGE_FIXED_PRIO_EN:
  - Defined: arbitration is fixed-priority, the lowest-index non-empty channel wins, and last_grant is not implemented.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- CH_NUM=2: channel 0 strobes 0xA at t and channel 1 strobes 0xB at t, almost_full=0. Required: writes 0xA at t+2 and 0xB at t+3, no overflow_err.
- CH_NUM=3: all channels strobe every cycle for 6 cycles. Required: output channel order 0,1,2,0,1,2…, with src_blocked asserting per BLOCK_SLACK.
- Hold almost_full=1 and push 5 words into channel 0 (BUF_DEPTH=4). Required: no rsp_write_en, src_blocked[0]=1 at count 3, 5th word dropped, overflow_err[0]=1. Release almost_full. Required: exactly 4 words out, in order.
- Channel full plus simultaneous push and pop. Required: push accepted, count stays 4, no error.
- Assert rst_n low with 3 words buffered. Required: outputs 0 immediately, no writes after release, overflow_err cleared.
- With RSP_MERGE_FIXED_PRIO_EN defined, channels 0 and 1 strobe continuously. Required: channel 1 output only after channel 0 stops.
